// File: rtl/bsg_axil_demux_n_pkg.sv
// Shared types and constants for the N-way AXI4-Lite address demultiplexer.
// The select index equal to the master count denotes the internal error target.
package bsg_axil_demux_pkg;

    typedef enum logic [1:0] {
        e_w_idle,
        e_w_fwd,
        e_w_resp
    } w_state_e;

    typedef enum logic [1:0] {
        e_r_idle,
        e_r_addr,
        e_r_data
    } r_state_e;

    localparam logic [1:0] axil_resp_okay   = 2'b00;
    localparam logic [1:0] axil_resp_decerr = 2'b11;

    // One extra select code is reserved for the DECERR target.
    function automatic int sel_width(input int num_m);
        return $clog2(num_m + 1);
    endfunction

endpackage

// File: rtl/bsg_axil_demux_n_if.sv
// AXI4-Lite bundle with num_p lanes flattened per signal; lane i occupies slice i.
// The master modport issues requests, the slave modport answers them.
interface bsg_axil_demux_n_if #(
    parameter int num_p        = 1,
    parameter int addr_width_p = 32,
    parameter int data_width_p = 32
);

    logic [num_p*addr_width_p-1:0]     awaddr;
    logic [num_p*3-1:0]                awprot;
    logic [num_p-1:0]                  awvalid;
    logic [num_p-1:0]                  awready;

    logic [num_p*data_width_p-1:0]     wdata;
    logic [num_p*(data_width_p/8)-1:0] wstrb;
    logic [num_p-1:0]                  wvalid;
    logic [num_p-1:0]                  wready;

    logic [num_p*2-1:0]                bresp;
    logic [num_p-1:0]                  bvalid;
    logic [num_p-1:0]                  bready;

    logic [num_p*addr_width_p-1:0]     araddr;
    logic [num_p*3-1:0]                arprot;
    logic [num_p-1:0]                  arvalid;
    logic [num_p-1:0]                  arready;

    logic [num_p*data_width_p-1:0]     rdata;
    logic [num_p*2-1:0]                rresp;
    logic [num_p-1:0]                  rvalid;
    logic [num_p-1:0]                  rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid,    input wready,
        input  bresp, bvalid,           output bready,
        output araddr, arprot, arvalid, input arready,
        input  rdata, rresp, rvalid,    output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid, output awready,
        input  wdata, wstrb, wvalid,    output wready,
        output bresp, bvalid,           input bready,
        input  araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid,    input rready
    );

endinterface

// File: rtl/bsg_axil_demux_n_addr_decode.sv
// Combinational base/mask address decoder; the lowest matching port index wins,
// and a miss selects index num_m_p (the error target).
module bsg_axil_addr_decode
    import bsg_axil_demux_pkg::*;
#(
    parameter int num_m_p      = 2,
    parameter int addr_width_p = 32,
    parameter logic [num_m_p*addr_width_p-1:0] base_addr_p = {32'h2000_0000, 32'h1000_0000},
    parameter logic [num_m_p*addr_width_p-1:0] addr_mask_p = {32'hF000_0000, 32'hF000_0000},
    localparam int sel_width_lp = sel_width(num_m_p)
) (
    input  logic [addr_width_p-1:0] addr,
    output logic [sel_width_lp-1:0] sel,
    output logic                    hit
);

    // Scan from the top down so the lowest index that matches is the one left standing.
    always_comb begin
        sel = sel_width_lp'(num_m_p);
        hit = 1'b0;
        for (int i = num_m_p - 1; i >= 0; i--) begin
            if ((addr & addr_mask_p[i*addr_width_p +: addr_width_p])
                    == base_addr_p[i*addr_width_p +: addr_width_p]) begin
                sel = sel_width_lp'(i);
                hit = 1'b1;
            end
        end
    end

    // Two windows overlap when their bases agree on every bit both masks compare.
    for (genvar i = 0; i < num_m_p; i++) begin : g_ov_i
        for (genvar j = i + 1; j < num_m_p; j++) begin : g_ov_j
            if (((base_addr_p[i*addr_width_p +: addr_width_p] ^ base_addr_p[j*addr_width_p +: addr_width_p])
                  & addr_mask_p[i*addr_width_p +: addr_width_p]
                  & addr_mask_p[j*addr_width_p +: addr_width_p]) == '0) begin : g_warn
                $warning("bsg_axil_addr_decode: address windows of ports %0d and %0d overlap", i, j);
            end
        end
    end

endmodule

// File: rtl/bsg_axil_demux_n.sv
// N-way AXI4-Lite demultiplexer: one slave port fanned out to num_m_p master ports by
// address, with independent read/write FSMs and an internal DECERR target for misses.
module bsg_axil_demux_n
    import bsg_axil_demux_pkg::*;
#(
    parameter int num_m_p      = 2,
    parameter int addr_width_p = 32,
    parameter int data_width_p = 32,
    parameter logic [num_m_p*addr_width_p-1:0] base_addr_p = {32'h2000_0000, 32'h1000_0000},
    parameter logic [num_m_p*addr_width_p-1:0] addr_mask_p = {32'hF000_0000, 32'hF000_0000},
    localparam int sel_width_lp = sel_width(num_m_p)
) (
    input  logic clk_i,
    input  logic reset_i,
    bsg_axil_demux_n_if.slave  s00_axil,
    bsg_axil_demux_n_if.master m_axil
);

    logic [sel_width_lp-1:0] aw_sel_dec, ar_sel_dec;
    logic                    aw_hit, ar_hit;

    bsg_axil_addr_decode #(
        .num_m_p(num_m_p), .addr_width_p(addr_width_p),
        .base_addr_p(base_addr_p), .addr_mask_p(addr_mask_p)
    ) aw_decode (
        .addr(s00_axil.awaddr), .sel(aw_sel_dec), .hit(aw_hit)
    );

    bsg_axil_addr_decode #(
        .num_m_p(num_m_p), .addr_width_p(addr_width_p),
        .base_addr_p(base_addr_p), .addr_mask_p(addr_mask_p)
    ) ar_decode (
        .addr(s00_axil.araddr), .sel(ar_sel_dec), .hit(ar_hit)
    );

    w_state_e                w_state_r, w_state_n;
    logic [sel_width_lp-1:0] w_sel_r;
    logic                    w_err_r;
    logic [addr_width_p-1:0] aw_addr_r;
    logic [2:0]              aw_prot_r;
    logic                    aw_done_r, aw_done_n;
    logic                    w_done_r, w_done_n;

    r_state_e                r_state_r, r_state_n;
    logic [sel_width_lp-1:0] r_sel_r;
    logic                    r_err_r;
    logic [addr_width_p-1:0] ar_addr_r;
    logic [2:0]              ar_prot_r;

    logic                    sel_awready, sel_wready, sel_bvalid;
    logic [1:0]              sel_bresp;
    logic                    sel_arready, sel_rvalid;
    logic [1:0]              sel_rresp;
    logic [data_width_p-1:0] sel_rdata;

    // Addresses and write data go to every port; only the selected lane sees valid.
    assign m_axil.awaddr = {num_m_p{aw_addr_r}};
    assign m_axil.awprot = {num_m_p{aw_prot_r}};
    assign m_axil.wdata  = {num_m_p{s00_axil.wdata}};
    assign m_axil.wstrb  = {num_m_p{s00_axil.wstrb}};
    assign m_axil.araddr = {num_m_p{ar_addr_r}};
    assign m_axil.arprot = {num_m_p{ar_prot_r}};

    always_comb begin
        sel_awready = 1'b0;
        sel_wready  = 1'b0;
        sel_bvalid  = 1'b0;
        sel_bresp   = axil_resp_okay;
        sel_arready = 1'b0;
        sel_rvalid  = 1'b0;
        sel_rresp   = axil_resp_okay;
        sel_rdata   = '0;
        for (int i = 0; i < num_m_p; i++) begin
            if (w_sel_r == sel_width_lp'(i)) begin
                sel_awready = m_axil.awready[i];
                sel_wready  = m_axil.wready[i];
                sel_bvalid  = m_axil.bvalid[i];
                sel_bresp   = m_axil.bresp[i*2 +: 2];
            end
            if (r_sel_r == sel_width_lp'(i)) begin
                sel_arready = m_axil.arready[i];
                sel_rvalid  = m_axil.rvalid[i];
                sel_rresp   = m_axil.rresp[i*2 +: 2];
                sel_rdata   = m_axil.rdata[i*data_width_p +: data_width_p];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            w_state_r <= e_w_idle;
            w_sel_r   <= '0;
            w_err_r   <= 1'b0;
            aw_addr_r <= '0;
            aw_prot_r <= '0;
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
        end else begin
            w_state_r <= w_state_n;
            aw_done_r <= aw_done_n;
            w_done_r  <= w_done_n;
            if (s00_axil.awvalid[0] && s00_axil.awready[0]) begin
                aw_addr_r <= s00_axil.awaddr;
                aw_prot_r <= s00_axil.awprot;
                w_sel_r   <= aw_sel_dec;
                w_err_r   <= !aw_hit;
            end
        end
    end

    // A miss marks the AW phase done at acceptance, so the error target only waits for W.
    always_comb begin
        w_state_n        = w_state_r;
        aw_done_n        = aw_done_r;
        w_done_n         = w_done_r;
        s00_axil.awready = 1'b0;
        s00_axil.wready  = 1'b0;
        s00_axil.bvalid  = 1'b0;
        s00_axil.bresp   = axil_resp_okay;
        m_axil.awvalid   = '0;
        m_axil.wvalid    = '0;
        m_axil.bready    = '0;
        unique case (w_state_r)
            e_w_idle: begin
                s00_axil.awready = !reset_i;
                if (s00_axil.awvalid[0] && !reset_i) begin
                    w_state_n = e_w_fwd;
                    aw_done_n = !aw_hit;
                    w_done_n  = 1'b0;
                end
            end
            e_w_fwd: begin
                for (int i = 0; i < num_m_p; i++) begin
                    if (w_sel_r == sel_width_lp'(i) && !w_err_r) begin
                        m_axil.awvalid[i] = !aw_done_r;
                        m_axil.wvalid[i]  = s00_axil.wvalid[0] && !w_done_r;
                    end
                end
                s00_axil.wready = !w_done_r && (w_err_r || sel_wready);
                if (!aw_done_r && !w_err_r && sel_awready)
                    aw_done_n = 1'b1;
                if (s00_axil.wvalid[0] && s00_axil.wready[0])
                    w_done_n = 1'b1;
                if (aw_done_n && w_done_n)
                    w_state_n = e_w_resp;
            end
            e_w_resp: begin
                s00_axil.bvalid = w_err_r || sel_bvalid;
                s00_axil.bresp  = w_err_r ? axil_resp_decerr : sel_bresp;
                for (int i = 0; i < num_m_p; i++) begin
                    m_axil.bready[i] = (w_sel_r == sel_width_lp'(i)) && !w_err_r && s00_axil.bready[0];
                end
                if (s00_axil.bvalid[0] && s00_axil.bready[0]) begin
                    w_state_n = e_w_idle;
                    aw_done_n = 1'b0;
                    w_done_n  = 1'b0;
                end
            end
            default: w_state_n = e_w_idle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state_r <= e_r_idle;
            r_sel_r   <= '0;
            r_err_r   <= 1'b0;
            ar_addr_r <= '0;
            ar_prot_r <= '0;
        end else begin
            r_state_r <= r_state_n;
            if (s00_axil.arvalid[0] && s00_axil.arready[0]) begin
                ar_addr_r <= s00_axil.araddr;
                ar_prot_r <= s00_axil.arprot;
                r_sel_r   <= ar_sel_dec;
                r_err_r   <= !ar_hit;
            end
        end
    end

    always_comb begin
        r_state_n        = r_state_r;
        s00_axil.arready = 1'b0;
        s00_axil.rvalid  = 1'b0;
        s00_axil.rresp   = axil_resp_okay;
        s00_axil.rdata   = '0;
        m_axil.arvalid   = '0;
        m_axil.rready    = '0;
        unique case (r_state_r)
            e_r_idle: begin
                s00_axil.arready = !reset_i;
                if (s00_axil.arvalid[0] && !reset_i)
                    r_state_n = ar_hit ? e_r_addr : e_r_data;
            end
            e_r_addr: begin
                for (int i = 0; i < num_m_p; i++) begin
                    m_axil.arvalid[i] = (r_sel_r == sel_width_lp'(i));
                end
                if (sel_arready)
                    r_state_n = e_r_data;
            end
            e_r_data: begin
                s00_axil.rvalid = r_err_r || sel_rvalid;
                s00_axil.rresp  = r_err_r ? axil_resp_decerr : sel_rresp;
                s00_axil.rdata  = r_err_r ? '0 : sel_rdata;
                for (int i = 0; i < num_m_p; i++) begin
                    m_axil.rready[i] = (r_sel_r == sel_width_lp'(i)) && !r_err_r && s00_axil.rready[0];
                end
                if (s00_axil.rvalid[0] && s00_axil.rready[0])
                    r_state_n = e_r_idle;
            end
            default: r_state_n = e_r_idle;
        endcase
    end

    // A master raising a response while it is not the one being waited on is a protocol violation.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            for (int i = 0; i < num_m_p; i++) begin
                assert (!m_axil.bvalid[i]
                        || (w_state_r == e_w_resp && !w_err_r && w_sel_r == sel_width_lp'(i)));
                assert (!m_axil.rvalid[i]
                        || (r_state_r == e_r_data && !r_err_r && r_sel_r == sel_width_lp'(i)));
            end
        end
    end

endmodule

// File: tb/tb_bsg_axil_demux_n.sv
// Directed bench for bsg_axil_demux_n with two master ports at 0x1xxx_xxxx and 0x2xxx_xxxx.
// Inputs change 1ns after the rising edge and outputs are sampled 1ns after that.
module tb_bsg_axil_demux_n;

    logic clk_i   = 1'b0;
    logic reset_i = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    bsg_axil_demux_n_if #(.num_p(1), .addr_width_p(32), .data_width_p(32)) s_if ();
    bsg_axil_demux_n_if #(.num_p(2), .addr_width_p(32), .data_width_p(32)) m_if ();

    bsg_axil_demux_n #(
        .num_m_p(2), .addr_width_p(32), .data_width_p(32),
        .base_addr_p({32'h2000_0000, 32'h1000_0000}),
        .addr_mask_p({32'hF000_0000, 32'hF000_0000})
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .s00_axil(s_if.slave), .m_axil(m_if.master)
    );

    always #5 clk_i = ~clk_i;

    task automatic step;
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs;
        s_if.awaddr = '0; s_if.awprot = '0; s_if.awvalid = '0;
        s_if.wdata  = '0; s_if.wstrb  = '0; s_if.wvalid  = '0; s_if.bready = '0;
        s_if.araddr = '0; s_if.arprot = '0; s_if.arvalid = '0; s_if.rready = '0;
        m_if.awready = '0; m_if.wready = '0; m_if.bresp = '0; m_if.bvalid = '0;
        m_if.arready = '0; m_if.rdata  = '0; m_if.rresp = '0; m_if.rvalid = '0;
    endtask

    task automatic test_reset;
        reset_i = 1'b1;
        clear_inputs();
        step(); step();
        checks++; if (s_if.awready !== 1'b0) begin failures++; $display("[TB] FAIL rst_awready got %b want 0", s_if.awready); end
        checks++; if (s_if.arready !== 1'b0) begin failures++; $display("[TB] FAIL rst_arready got %b want 0", s_if.arready); end
        checks++; if ({m_if.awvalid, m_if.wvalid, m_if.arvalid, s_if.bvalid, s_if.rvalid} !== 7'b0) begin
            failures++; $display("[TB] FAIL rst_valids got %b want 0", {m_if.awvalid, m_if.wvalid, m_if.arvalid, s_if.bvalid, s_if.rvalid}); end
        reset_i = 1'b0;
        #1;
        checks++; if ({s_if.awready, s_if.arready} !== 2'b11) begin failures++; $display("[TB] FAIL rst_release_ready got %b want 11", {s_if.awready, s_if.arready}); end
    endtask

    task automatic test_write_m0;
        s_if.awvalid = 1'b1; s_if.awaddr = 32'h1000_0004; s_if.awprot = 3'b010;
        s_if.wvalid = 1'b1; s_if.wdata = 32'hDEAD_BEEF; s_if.wstrb = 4'hF;
        #1;
        checks++; if (s_if.wready !== 1'b0) begin failures++; $display("[TB] FAIL wr_idle_wready got %b want 0", s_if.wready); end
        step();
        s_if.awvalid = 1'b0;
        #1;
        checks++; if (m_if.awvalid !== 2'b01) begin failures++; $display("[TB] FAIL wr_m_awvalid got %b want 01", m_if.awvalid); end
        checks++; if (m_if.awaddr[31:0] !== 32'h1000_0004) begin failures++; $display("[TB] FAIL wr_m_awaddr got %h want 10000004", m_if.awaddr[31:0]); end
        checks++; if (m_if.awprot[2:0] !== 3'b010) begin failures++; $display("[TB] FAIL wr_m_awprot got %b want 010", m_if.awprot[2:0]); end
        checks++; if (m_if.wvalid !== 2'b01) begin failures++; $display("[TB] FAIL wr_m_wvalid got %b want 01", m_if.wvalid); end
        checks++; if (m_if.wdata[31:0] !== 32'hDEAD_BEEF) begin failures++; $display("[TB] FAIL wr_m_wdata got %h want deadbeef", m_if.wdata[31:0]); end
        checks++; if ({s_if.wready, s_if.awready} !== 2'b00) begin failures++; $display("[TB] FAIL wr_fwd_readies got %b want 00", {s_if.wready, s_if.awready}); end
        m_if.awready = 2'b01; m_if.wready = 2'b01;
        #1;
        checks++; if (s_if.wready !== 1'b1) begin failures++; $display("[TB] FAIL wr_wready_pass got %b want 1", s_if.wready); end
        step();
        m_if.awready = '0; m_if.wready = '0; s_if.wvalid = 1'b0;
        m_if.bvalid = 2'b01; m_if.bresp = 4'b0010; s_if.bready = 1'b1;
        #1;
        checks++; if ({m_if.awvalid, m_if.wvalid} !== 4'b0) begin failures++; $display("[TB] FAIL wr_resp_mvalids got %b want 0000", {m_if.awvalid, m_if.wvalid}); end
        checks++; if (s_if.bvalid !== 1'b1 || s_if.bresp !== 2'b10) begin
            failures++; $display("[TB] FAIL wr_bresp_pass got v=%b r=%b want v=1 r=10", s_if.bvalid, s_if.bresp); end
        checks++; if (m_if.bready !== 2'b01) begin failures++; $display("[TB] FAIL wr_m_bready got %b want 01", m_if.bready); end
        step();
        m_if.bvalid = '0; m_if.bresp = '0; s_if.bready = 1'b0;
        #1;
        checks++; if (s_if.awready !== 1'b1 || s_if.bvalid !== 1'b0) begin
            failures++; $display("[TB] FAIL wr_back_idle got awready=%b bvalid=%b want 1 0", s_if.awready, s_if.bvalid); end
    endtask

    task automatic test_read_m1;
        s_if.arvalid = 1'b1; s_if.araddr = 32'h2000_0010;
        #1;
        checks++; if (s_if.arready !== 1'b1) begin failures++; $display("[TB] FAIL rd_arready got %b want 1", s_if.arready); end
        step();
        s_if.arvalid = 1'b0;
        #1;
        checks++; if (m_if.arvalid !== 2'b10) begin failures++; $display("[TB] FAIL rd_m_arvalid got %b want 10", m_if.arvalid); end
        checks++; if (m_if.araddr[63:32] !== 32'h2000_0010) begin failures++; $display("[TB] FAIL rd_m_araddr got %h want 20000010", m_if.araddr[63:32]); end
        m_if.arready = 2'b10;
        step();
        m_if.arready = '0;
        m_if.rvalid = 2'b10; m_if.rdata = {32'h1234_5678, 32'hFFFF_FFFF}; m_if.rresp = 4'b0000;
        s_if.rready = 1'b1;
        #1;
        checks++; if (m_if.arvalid !== 2'b00) begin failures++; $display("[TB] FAIL rd_arvalid_drop got %b want 00", m_if.arvalid); end
        checks++; if (s_if.rvalid !== 1'b1 || s_if.rdata !== 32'h1234_5678 || s_if.rresp !== 2'b00) begin
            failures++; $display("[TB] FAIL rd_data_pass got v=%b d=%h r=%b want 1 12345678 00", s_if.rvalid, s_if.rdata, s_if.rresp); end
        checks++; if (m_if.rready !== 2'b10) begin failures++; $display("[TB] FAIL rd_m_rready got %b want 10", m_if.rready); end
        step();
        m_if.rvalid = '0; m_if.rdata = '0; s_if.rready = 1'b0;
        #1;
        checks++; if (s_if.arready !== 1'b1) begin failures++; $display("[TB] FAIL rd_back_idle got %b want 1", s_if.arready); end
    endtask

    task automatic test_read_unmapped;
        s_if.arvalid = 1'b1; s_if.araddr = 32'h3000_0000;
        step();
        s_if.arvalid = 1'b0;
        #1;
        checks++; if (s_if.rvalid !== 1'b1 || s_if.rdata !== 32'h0 || s_if.rresp !== 2'b11) begin
            failures++; $display("[TB] FAIL rd_err_resp got v=%b d=%h r=%b want 1 00000000 11", s_if.rvalid, s_if.rdata, s_if.rresp); end
        checks++; if (m_if.arvalid !== 2'b00) begin failures++; $display("[TB] FAIL rd_err_no_arvalid got %b want 00", m_if.arvalid); end
        s_if.rready = 1'b1;
        step();
        s_if.rready = 1'b0;
        #1;
        checks++; if (s_if.rvalid !== 1'b0 || s_if.arready !== 1'b1) begin
            failures++; $display("[TB] FAIL rd_err_done got rvalid=%b arready=%b want 0 1", s_if.rvalid, s_if.arready); end
    endtask

    task automatic test_write_unmapped_late_w;
        logic early = 1'b0;
        s_if.awvalid = 1'b1; s_if.awaddr = 32'h3000_0000;
        step();
        s_if.awvalid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            if (s_if.bvalid !== 1'b0 || m_if.awvalid !== 2'b00) early = 1'b1;
            step();
        end
        checks++; if (early !== 1'b0) begin failures++; $display("[TB] FAIL wr_err_early_b got %b want 0", early); end
        s_if.wvalid = 1'b1; s_if.wdata = 32'h0000_1111; s_if.wstrb = 4'hF;
        #1;
        checks++; if (s_if.wready !== 1'b1 || m_if.wvalid !== 2'b00) begin
            failures++; $display("[TB] FAIL wr_err_wready got wready=%b mwvalid=%b want 1 00", s_if.wready, m_if.wvalid); end
        step();
        s_if.wvalid = 1'b0;
        #1;
        checks++; if (s_if.bvalid !== 1'b1 || s_if.bresp !== 2'b11) begin
            failures++; $display("[TB] FAIL wr_err_bresp got v=%b r=%b want 1 11", s_if.bvalid, s_if.bresp); end
        s_if.bready = 1'b1;
        step();
        s_if.bready = 1'b0;
        #1;
        checks++; if (s_if.awready !== 1'b1 || s_if.bvalid !== 1'b0) begin
            failures++; $display("[TB] FAIL wr_err_done got awready=%b bvalid=%b want 1 0", s_if.awready, s_if.bvalid); end
    endtask

    task automatic test_back_to_back_concurrent;
        logic held_bad = 1'b0;
        s_if.awvalid = 1'b1; s_if.awaddr = 32'h1000_0020;
        s_if.wvalid = 1'b1; s_if.wdata = 32'hA5A5_0001; s_if.wstrb = 4'h3;
        s_if.arvalid = 1'b1; s_if.araddr = 32'h2000_0040;
        #1;
        checks++; if ({s_if.awready, s_if.arready} !== 2'b11) begin failures++; $display("[TB] FAIL cc_accept got %b want 11", {s_if.awready, s_if.arready}); end
        step();
        s_if.awvalid = 1'b0; s_if.arvalid = 1'b0;
        m_if.awready = 2'b01; m_if.wready = 2'b01; m_if.arready = 2'b10;
        #1;
        checks++; if ({m_if.awvalid, m_if.arvalid, m_if.wstrb[3:0]} !== 8'b01_10_0011) begin
            failures++; $display("[TB] FAIL cc_fwd got %b want 01100011", {m_if.awvalid, m_if.arvalid, m_if.wstrb[3:0]}); end
        step();
        m_if.awready = '0; m_if.wready = '0; m_if.arready = '0; s_if.wvalid = 1'b0;
        m_if.bvalid = 2'b01; m_if.bresp = 4'b0000;
        m_if.rvalid = 2'b10; m_if.rdata = {32'hCAFE_F00D, 32'h0}; m_if.rresp = 4'b0000;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (s_if.awready !== 1'b0 || s_if.arready !== 1'b0 || s_if.bvalid !== 1'b1 || s_if.rvalid !== 1'b1) held_bad = 1'b1;
            step();
        end
        checks++; if (held_bad !== 1'b0) begin failures++; $display("[TB] FAIL cc_hold got %b want 0", held_bad); end
        s_if.bready = 1'b1; s_if.rready = 1'b1;
        #1;
        checks++; if (s_if.rdata !== 32'hCAFE_F00D || m_if.rready !== 2'b10 || m_if.bready !== 2'b01) begin
            failures++; $display("[TB] FAIL cc_resp got rdata=%h rready=%b bready=%b want cafef00d 10 01", s_if.rdata, m_if.rready, m_if.bready); end
        step();
        m_if.bvalid = '0; m_if.rvalid = '0; m_if.rdata = '0; s_if.bready = 1'b0; s_if.rready = 1'b0;
        #1;
        checks++; if ({s_if.awready, s_if.arready} !== 2'b11) begin failures++; $display("[TB] FAIL cc_done got %b want 11", {s_if.awready, s_if.arready}); end
    endtask

    task automatic test_reset_mid_write;
        s_if.awvalid = 1'b1; s_if.awaddr = 32'h1000_0008;
        s_if.wvalid = 1'b1; s_if.wdata = 32'h5555_AAAA; s_if.wstrb = 4'hF;
        step();
        s_if.awvalid = 1'b0;
        #1;
        checks++; if (m_if.awvalid !== 2'b01) begin failures++; $display("[TB] FAIL mr_stall got %b want 01", m_if.awvalid); end
        reset_i = 1'b1;
        step();
        s_if.wvalid = 1'b0;
        #1;
        checks++; if ({m_if.awvalid, m_if.wvalid, s_if.bvalid, s_if.awready} !== 6'b0) begin
            failures++; $display("[TB] FAIL mr_in_reset got %b want 000000", {m_if.awvalid, m_if.wvalid, s_if.bvalid, s_if.awready}); end
        reset_i = 1'b0;
        s_if.awvalid = 1'b1; s_if.awaddr = 32'h1000_000C;
        s_if.wvalid = 1'b1; s_if.wdata = 32'h0BAD_F00D;
        #1;
        checks++; if (s_if.awready !== 1'b1) begin failures++; $display("[TB] FAIL mr_after_awready got %b want 1", s_if.awready); end
        step();
        s_if.awvalid = 1'b0;
        m_if.awready = 2'b01; m_if.wready = 2'b01;
        #1;
        checks++; if (m_if.awaddr[31:0] !== 32'h1000_000C || m_if.wdata[31:0] !== 32'h0BAD_F00D || m_if.awvalid !== 2'b01) begin
            failures++; $display("[TB] FAIL mr_new_write got addr=%h data=%h v=%b want 1000000c 0badf00d 01", m_if.awaddr[31:0], m_if.wdata[31:0], m_if.awvalid); end
        step();
        m_if.awready = '0; m_if.wready = '0; s_if.wvalid = 1'b0;
        m_if.bvalid = 2'b01; m_if.bresp = 4'b0000; s_if.bready = 1'b1;
        #1;
        checks++; if (s_if.bvalid !== 1'b1 || s_if.bresp !== 2'b00) begin
            failures++; $display("[TB] FAIL mr_bresp got v=%b r=%b want 1 00", s_if.bvalid, s_if.bresp); end
        step();
        m_if.bvalid = '0; s_if.bready = 1'b0;
        #1;
        checks++; if (s_if.awready !== 1'b1) begin failures++; $display("[TB] FAIL mr_done got %b want 1", s_if.awready); end
    endtask

    initial begin
        $display("[TB] starting bsg_axil_demux_n directed tests");
        test_reset();
        test_write_m0();
        test_read_m1();
        test_read_unmapped();
        test_write_unmapped_late_w();
        test_back_to_back_concurrent();
        test_reset_mid_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
